// File: rtl/dsp_seq_pkg.sv
// ---------------------------------------------------------------------------
// dsp_seq_pkg
// Shared definitions for the DSP48A1 multiply-accumulate sequencer.
//  - FSM state encodings (kept as plain localparam constants so older
//    tools that choke on enums in ports still compile this slice)
//  - OPMODE words driven to the slice
//  - the per-element tag that rides alongside the slice pipeline
// No ports: package only.
// ---------------------------------------------------------------------------
package dsp_seq_pkg;

   typedef logic [1:0] seqState_t;

   localparam seqState_t ST_IDLE  = 2'd0;
   localparam seqState_t ST_ISSUE = 2'd1;
   localparam seqState_t ST_DRAIN = 2'd2;
   localparam seqState_t ST_DONE  = 2'd3;

   // OPMODE[1:0] selects X (01 = M), OPMODE[3:2] selects Z (00 = 0, 10 = P)
   localparam logic [7:0] OPM_NOP = 8'h00;
   localparam logic [7:0] OPM_MUL = 8'h01;
   localparam logic [7:0] OPM_MAC = 8'h09;

   typedef struct packed {
      logic live;
      logic first;
      logic last;
   } seqTag_t;

   localparam seqTag_t TAG_NONE = '0;

endpackage

// File: rtl/dsp_seq_tagpipe.sv
// ---------------------------------------------------------------------------
// dsp_seq_tagpipe
// LAT-deep shift register of element tags that mirrors the slice pipeline
// (A1 register, M register, P register). Stage 0 lines up with the slice
// A1/B1 registers, stage LAT-1 with the P register. Shifts every cycle;
// bubbles are simply tags with live=0.
// Ports:
//   clk         in   rising-edge clock
//   RSTA        in   asynchronous active-high clear of every stage
//   tag_i       in   tag presented together with the slice A/B inputs
//   tapLive_o   out  live bit of the tag at stage OPM_TAP
//   tapFirst_o  out  first bit of the tag at stage OPM_TAP
//   retire_o    out  a live, last tag sits in the final stage (P valid)
// ---------------------------------------------------------------------------
module dsp_seq_tagpipe
   import dsp_seq_pkg::*;
#(
   parameter int LAT     = 3,
   parameter int OPM_TAP = 1
)
(
   input  logic    clk,
   input  logic    RSTA,
   input  seqTag_t tag_i,
   output logic    tapLive_o,
   output logic    tapFirst_o,
   output logic    retire_o
);

   seqTag_t pipe_q [LAT];

   // Plain shift: every stage advances each cycle whether or not it holds
   // a live element, so the tag position always equals the slice stage.
   always_ff @(posedge clk or posedge RSTA) begin
      if (RSTA) begin
         for (int k = 0; k < LAT; k++) begin
            pipe_q[k] <= TAG_NONE;
         end
      end else begin
         pipe_q[0] <= tag_i;
         for (int k = 1; k < LAT; k++) begin
            pipe_q[k] <= pipe_q[k-1];
         end
      end
   end

   // The tap stage is where the post-adder consumes M; the final stage is
   // the cycle in which P holds the sum including this element.
   assign tapLive_o  = pipe_q[OPM_TAP].live;
   assign tapFirst_o = pipe_q[OPM_TAP].first;
   assign retire_o   = pipe_q[LAT-1].live & pipe_q[LAT-1].last;

endmodule

// File: rtl/dsp48a1_mac_sequencer.sv
// ---------------------------------------------------------------------------
// dsp48a1_mac_sequencer
// Feeds a counted stream of signed 18x18 operand pairs into one DSP48A1
// slice (A1REG=1, MREG=1, PREG=1, OPMODEREG=0) and returns one 48-bit dot
// product per job on a valid/ready port.
// Optional feature: define DSP_SEQ_SAT_EN to clamp the result to a signed
// SAT_W-bit range (sign-extended to 48 bits) and flag res_ovf when clamped.
// Ports:
//   clk, RSTA                 clock, asynchronous active-high reset
//   start, len                job start (IDLE only) and element count
//   s_valid/s_ready/s_a/s_b   operand stream
//   dsp_a, dsp_b              registered operands to the slice
//   dsp_opmode, dsp_cep       per-element OPMODE and P clock enable
//   dsp_rstp                  one-cycle P reset at job start
//   dsp_p                     slice P output
//   res_valid/res_ready       result handshake
//   res_data, res_ovf         dot product and saturation flag
//   busy                      sequencer not idle
// ---------------------------------------------------------------------------
module dsp48a1_mac_sequencer
   import dsp_seq_pkg::*;
#(
   parameter int LAT     = 3,
   parameter int OPM_TAP = 1,
   parameter int LEN_W   = 16,
   parameter int SAT_W   = 36
)
(
   input  logic                clk,
   input  logic                RSTA,
   input  logic                start,
   input  logic [LEN_W-1:0]    len,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic signed [17:0]  s_a,
   input  logic signed [17:0]  s_b,
   output logic [17:0]         dsp_a,
   output logic [17:0]         dsp_b,
   output logic [7:0]          dsp_opmode,
   output logic                dsp_cep,
   output logic                dsp_rstp,
   input  logic [47:0]         dsp_p,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [47:0]         res_data,
   output logic                res_ovf,
   output logic                busy
);

   localparam logic [LEN_W-1:0] LEN_ONE = 1;

   if ((OPM_TAP < 0) || (OPM_TAP >= LAT) || (SAT_W < 1) || (SAT_W > 48)) begin : gBadParams
      $error("dsp48a1_mac_sequencer: OPM_TAP must be in 0..LAT-1 and SAT_W in 1..48");
   end

   seqState_t         state_q, state_d;
   logic [LEN_W-1:0]  issued_q, issued_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [17:0]       dspA_q, dspA_d;
   logic [17:0]       dspB_q, dspB_d;
   seqTag_t           issueTag_q, issueTag_d;
   logic              rstp_q, rstp_d;
   logic [47:0]       resData_q, resData_d;
   logic              resOvf_q, resOvf_d;

   logic              accept;
   logic              lastIssue;
   logic              tapLive;
   logic              tapFirst;
   logic              retire;
   logic [47:0]       satData;
   logic              satOvf;

   assign s_ready   = (state_q == ST_ISSUE);
   assign accept    = s_valid & s_ready;
   assign lastIssue = (issued_q == (len_q - LEN_ONE));

   // The issue register (dspA/dspB/issueTag) sits one cycle ahead of the
   // slice A1 register, so the tag pipeline proper starts at A1.
   dsp_seq_tagpipe #(
      .LAT     (LAT),
      .OPM_TAP (OPM_TAP)
   ) u_tagpipe (
      .clk        (clk),
      .RSTA       (RSTA),
      .tag_i      (issueTag_q),
      .tapLive_o  (tapLive),
      .tapFirst_o (tapFirst),
      .retire_o   (retire)
   );

   // Result shaping. With saturation the raw 48-bit slice sum is clamped to
   // the signed SAT_W range; otherwise P is passed through untouched.
`ifdef DSP_SEQ_SAT_EN
   localparam logic signed [47:0] SAT_MAX = (48'sd1 <<< (SAT_W - 1)) - 48'sd1;
   localparam logic signed [47:0] SAT_MIN = -(48'sd1 <<< (SAT_W - 1));

   always_comb begin
      satData = dsp_p;
      satOvf  = 1'b0;
      if ($signed(dsp_p) > SAT_MAX) begin
         satData = SAT_MAX;
         satOvf  = 1'b1;
      end else if ($signed(dsp_p) < SAT_MIN) begin
         satData = SAT_MIN;
         satOvf  = 1'b1;
      end
   end
`else
   assign satData = dsp_p;
   assign satOvf  = 1'b0;
`endif

   // Job sequencing. A zero-length job skips the slice entirely and posts a
   // zero result. In ISSUE every cycle produces either a live tag (accept)
   // or a bubble; bubbles keep CEP low so P never re-adds a stale M.
   always_comb begin
      state_d    = state_q;
      issued_d   = issued_q;
      len_d      = len_q;
      dspA_d     = dspA_q;
      dspB_d     = dspB_q;
      issueTag_d = TAG_NONE;
      rstp_d     = 1'b0;
      resData_d  = resData_q;
      resOvf_d   = resOvf_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               len_d    = len;
               issued_d = '0;
               if (len != '0) begin
                  state_d = ST_ISSUE;
                  rstp_d  = 1'b1;
               end else begin
                  state_d   = ST_DONE;
                  resData_d = '0;
                  resOvf_d  = 1'b0;
               end
            end
         end
         ST_ISSUE: begin
            if (accept) begin
               dspA_d           = s_a;
               dspB_d           = s_b;
               issueTag_d.live  = 1'b1;
               issueTag_d.first = (issued_q == '0);
               issueTag_d.last  = lastIssue;
               issued_d         = issued_q + LEN_ONE;
               if (lastIssue) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (retire) begin
               resData_d = satData;
               resOvf_d  = satOvf;
               state_d   = ST_DONE;
            end
         end
         ST_DONE: begin
            if (res_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any job in flight.
   always_ff @(posedge clk or posedge RSTA) begin
      if (RSTA) begin
         state_q    <= ST_IDLE;
         issued_q   <= '0;
         len_q      <= '0;
         dspA_q     <= '0;
         dspB_q     <= '0;
         issueTag_q <= TAG_NONE;
         rstp_q     <= 1'b0;
         resData_q  <= '0;
         resOvf_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         issued_q   <= issued_d;
         len_q      <= len_d;
         dspA_q     <= dspA_d;
         dspB_q     <= dspB_d;
         issueTag_q <= issueTag_d;
         rstp_q     <= rstp_d;
         resData_q  <= resData_d;
         resOvf_q   <= resOvf_d;
      end
   end

   // OPMODE is combinational from the tap because the slice does not
   // register it: the value must be present while M feeds the post-adder.
   assign dsp_opmode = tapLive ? (tapFirst ? OPM_MUL : OPM_MAC) : OPM_NOP;
   assign dsp_cep    = tapLive;
   assign dsp_a      = dspA_q;
   assign dsp_b      = dspB_q;
   assign dsp_rstp   = rstp_q;
   assign res_valid  = (state_q == ST_DONE);
   assign res_data   = resData_q;
   assign res_ovf    = resOvf_q;
   assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dsp48a1_mac_sequencer.sv
// ---------------------------------------------------------------------------
// tb_dsp48a1_mac_sequencer
// Directed bench: the sequencer drives a small behavioural DSP48A1 slice
// (A1REG=1, MREG=1, PREG=1, OPMODEREG=0) and every result is compared with
// hand-computed constants.
// ---------------------------------------------------------------------------
module tb_dsp48a1_mac_sequencer;

   logic               clk;
   logic               RSTA;
   logic               start;
   logic [15:0]        len;
   logic               s_valid;
   logic               s_ready;
   logic signed [17:0] s_a;
   logic signed [17:0] s_b;
   logic [17:0]        dsp_a;
   logic [17:0]        dsp_b;
   logic [7:0]         dsp_opmode;
   logic               dsp_cep;
   logic               dsp_rstp;
   logic [47:0]        dsp_p;
   logic               res_valid;
   logic               res_ready;
   logic [47:0]        res_data;
   logic               res_ovf;
   logic               busy;

   int                 total;
   int                 bad;
   int                 cepCnt;
   int                 lat;
   logic [23:0]        opmLog;
   logic               rstpSeen;
   logic signed [17:0] opA [0:7];
   logic signed [17:0] opB [0:7];

   dsp48a1_mac_sequencer dut (
      .clk        (clk),
      .RSTA       (RSTA),
      .start      (start),
      .len        (len),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_a        (s_a),
      .s_b        (s_b),
      .dsp_a      (dsp_a),
      .dsp_b      (dsp_b),
      .dsp_opmode (dsp_opmode),
      .dsp_cep    (dsp_cep),
      .dsp_rstp   (dsp_rstp),
      .dsp_p      (dsp_p),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_data   (res_data),
      .res_ovf    (res_ovf),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural slice: A1/B1 and M free-run, P updates only with CEP.
   logic signed [17:0] a1;
   logic signed [17:0] b1;
   logic signed [35:0] mReg;
   logic signed [47:0] pReg;
   logic signed [47:0] xMux;
   logic signed [47:0] zMux;

   assign xMux  = (dsp_opmode[1:0] == 2'b01) ? {{12{mReg[35]}}, mReg} : 48'sd0;
   assign zMux  = (dsp_opmode[3:2] == 2'b10) ? pReg : 48'sd0;
   assign dsp_p = pReg;

   always_ff @(posedge clk or posedge RSTA) begin
      if (RSTA) begin
         a1   <= '0;
         b1   <= '0;
         mReg <= '0;
         pReg <= '0;
      end else begin
         a1   <= dsp_a;
         b1   <= dsp_b;
         mReg <= a1 * b1;
         if (dsp_rstp) begin
            pReg <= '0;
         end else if (dsp_cep) begin
            pReg <= zMux + xMux;
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One cycle: move to the next falling edge and log CEP/OPMODE activity.
   task automatic tick();
      @(negedge clk);
      if (dsp_cep === 1'b1) begin
         cepCnt++;
         opmLog = {opmLog[15:0], dsp_opmode};
      end
   endtask

   // Starts a job from IDLE and feeds n pairs with gap idle cycles between
   // them; returns once res_valid is seen (lat counts cycles after the last
   // accept edge) or the wait expires.
   task automatic applyStimulus(input int n, input int gap);
      cepCnt   = 0;
      opmLog   = '0;
      lat      = 0;
      start    = 1'b1;
      len      = 16'(n);
      tick();
      start    = 1'b0;
      rstpSeen = dsp_rstp;
      for (int i = 0; i < n; i++) begin
         s_valid = 1'b1;
         s_a     = opA[i];
         s_b     = opB[i];
         checkOutput("sReady", {63'd0, s_ready}, 64'd1);
         tick();
         s_valid = 1'b0;
         if (i != n - 1) begin
            for (int g = 0; g < gap; g++) tick();
         end
      end
      while (res_valid !== 1'b1 && lat < 50) begin
         tick();
         lat++;
      end
   endtask

   task automatic releaseResult();
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      checkOutput("idleAfterAck", {62'd0, busy, res_valid}, 64'd0);
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      cepCnt    = 0;
      opmLog    = '0;
      lat       = 0;
      rstpSeen  = 1'b0;
      RSTA      = 1'b1;
      start     = 1'b0;
      len       = '0;
      s_valid   = 1'b0;
      s_a       = '0;
      s_b       = '0;
      res_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         opA[i] = '0;
         opB[i] = '0;
      end

      // Reset state
      tick();
      checkOutput("rstReady",  {63'd0, s_ready}, 64'd0);
      checkOutput("rstBusy",   {63'd0, busy}, 64'd0);
      checkOutput("rstValid",  {63'd0, res_valid}, 64'd0);
      checkOutput("rstData",   {16'd0, res_data}, 64'd0);
      checkOutput("rstOpmode", {56'd0, dsp_opmode}, 64'd0);
      checkOutput("rstCepRstp", {62'd0, dsp_cep, dsp_rstp}, 64'd0);
      checkOutput("rstAB",     {28'd0, dsp_a, dsp_b}, 64'd0);
      RSTA = 1'b0;
      tick();

      // Back-to-back job: 2*3 + 4*5 + (-1)*7 = 19
      opA[0] = 18'sd2;  opB[0] = 18'sd3;
      opA[1] = 18'sd4;  opB[1] = 18'sd5;
      opA[2] = -18'sd1; opB[2] = 18'sd7;
      applyStimulus(3, 0);
      checkOutput("b2bRstp",  {63'd0, rstpSeen}, 64'd1);
      checkOutput("b2bLat",   64'(lat), 64'd4);
      checkOutput("b2bData",  {16'd0, res_data}, 64'd19);
      checkOutput("b2bOvf",   {63'd0, res_ovf}, 64'd0);
      checkOutput("b2bCep",   64'(cepCnt), 64'd3);
      checkOutput("b2bOpm",   {40'd0, opmLog}, 64'h010909);

      // Result held in DONE with res_ready low; a start pulse must be ignored
      start = 1'b1;
      len   = 16'd5;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      checkOutput("holdData",  {16'd0, res_data}, 64'd19);
      checkOutput("holdFlags", {61'd0, res_valid, s_ready, busy}, 64'b101);
      releaseResult();
      tick();
      checkOutput("idleStays", {62'd0, busy, s_ready}, 64'd0);

      // Same job with two idle cycles between pairs
      applyStimulus(3, 2);
      checkOutput("gapLat",  64'(lat), 64'd4);
      checkOutput("gapData", {16'd0, res_data}, 64'd19);
      checkOutput("gapCep",  64'(cepCnt), 64'd3);
      checkOutput("gapOpm",  {40'd0, opmLog}, 64'h010909);
      releaseResult();

      // Zero-length job: result right away, slice never enabled
      applyStimulus(0, 0);
      checkOutput("zeroLat",  64'(lat), 64'd0);
      checkOutput("zeroData", {16'd0, res_data}, 64'd0);
      checkOutput("zeroCep",  64'(cepCnt), 64'd0);
      checkOutput("zeroRstp", {63'd0, rstpSeen}, 64'd0);
      releaseResult();

      // Abort after 2 of 4 accepts
      opA[0] = 18'sd5; opB[0] = 18'sd6;
      opA[1] = 18'sd7; opB[1] = 18'sd8;
      start = 1'b1;
      len   = 16'd4;
      tick();
      start   = 1'b0;
      s_valid = 1'b1;
      s_a     = opA[0];
      s_b     = opB[0];
      tick();
      s_a     = opA[1];
      s_b     = opB[1];
      tick();
      s_valid = 1'b0;
      tick();
      checkOutput("preAbortCep", {63'd0, dsp_cep}, 64'd1);
      RSTA = 1'b1;
      #1;
      checkOutput("abortFlags", {59'd0, busy, s_ready, res_valid, dsp_cep, dsp_rstp}, 64'd0);
      checkOutput("abortDsp",   {20'd0, dsp_opmode, dsp_a, dsp_b}, 64'd0);
      tick();
      RSTA = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      checkOutput("abortNoRes", {62'd0, res_valid, busy}, 64'd0);

      // New job after the abort: (-3)*(-3) = 9
      opA[0] = -18'sd3; opB[0] = -18'sd3;
      applyStimulus(1, 0);
      checkOutput("postAbortLat",  64'(lat), 64'd4);
      checkOutput("postAbortData", {16'd0, res_data}, 64'd9);
      releaseResult();

      // Two max-magnitude products: 2*(2^17-1)^2 = 0x7FFF80002, below 2^35-1
      opA[0] = 18'sd131071; opB[0] = 18'sd131071;
      opA[1] = 18'sd131071; opB[1] = 18'sd131071;
      opA[2] = 18'sd131071; opB[2] = 18'sd131071;
      applyStimulus(2, 0);
      checkOutput("bigData", {16'd0, res_data}, 64'h7FFF80002);
      checkOutput("bigOvf",  {63'd0, res_ovf}, 64'd0);
      releaseResult();

      // Three products: 0xBFFF40003 exceeds the 36-bit signed range
      applyStimulus(3, 0);
`ifdef DSP_SEQ_SAT_EN
      checkOutput("ovfData", {16'd0, res_data}, 64'h7FFFFFFFF);
      checkOutput("ovfFlag", {63'd0, res_ovf}, 64'd1);
`else
      checkOutput("ovfData", {16'd0, res_data}, 64'hBFFF40003);
      checkOutput("ovfFlag", {63'd0, res_ovf}, 64'd0);
`endif
      releaseResult();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
